core_if_id: RTL and testbench
=============================

// Module: core_if_id
// PURPOSE
// - IF->ID pipeline register. Captures the fetched instruction and its address from fetch and presents them
//   to the decode stage's inst_in / inst_addr_in.
// - valid/ready handshake on both sides; 2-entry skid buffering so the fetch-side ready is registered.
// - Branch/jump flush injects a NOP bubble.
// PARAMETERS
// - INST_W      32             instruction width
// - ADDR_W      32             instruction address width
// - NOP_INST    32'h0000_0013  bubble instruction (addi x0,x0,0)
// PORTS
// - clk            in   1       clock, all state updates on rising edge
// - rst            in   1       synchronous active-high reset
// - if_valid_in    in   1       fetch presents a valid instruction
// - if_ready_out   out  1       stage can accept this cycle
// - inst_in        in   INST_W  fetched instruction
// - inst_addr_in   in   ADDR_W  fetched instruction address
// - flush_in       in   1       discard all held/incoming instructions (taken branch/jump)
// - id_ready_in    in   1       decode consumes current output this cycle (0 = hazard stall)
// - id_valid_out   out  1       inst_out/inst_addr_out valid
// - inst_out       out  INST_W  instruction to decode
// - inst_addr_out  out  ADDR_W  address to decode
// BEHAVIOUR
// - State: main reg {m_v, m_inst, m_addr} drives outputs directly; skid reg {s_v, s_inst, s_addr}.
// - Reset: m_v=0, s_v=0, inst_out=NOP_INST, inst_addr_out=0, id_valid_out=0, if_ready_out=1.
// - accept = if_valid_in & if_ready_out; advance = id_ready_in | ~m_v.
// - if_ready_out = ~s_v (flop-derived, no comb path from id_ready_in).
// - advance & s_v: main<=skid, s_v<=0; the incoming beat, if accepted, goes into skid (s_v<=1).
// - advance & ~s_v: main<=incoming if accepted; else m_v<=0, inst_out<=NOP_INST, addr held.
// - ~advance & accept: skid<=incoming, s_v<=1 (at most one beat lands in skid; ready drops next cycle).
// - ~advance & ~accept: all state held.
// - Latency: 1 cycle input->output when unstalled; throughput 1 inst/cycle sustained.
// - Program order always preserved; no beat dropped or duplicated except by flush.
// - flush_in: beats current main, skid and the same-cycle input are discarded.
//   Next cycle: m_v=0, s_v=0, inst_out=NOP_INST, if_ready_out=1.
// - Priority: rst > flush_in > handshake logic.
// - id_ready_in with m_v=0: no effect other than enabling advance.
// - Reset asserted mid-stall: all in-flight beats lost, reset values next cycle.
// - Widths: no arithmetic; all transfers full-width copies.
// CONFIGURATION
// - CORE_IF_ID_SKID_EN defined: behaviour above (2 entries, registered if_ready_out).
// - Undefined: skid regs removed; if_ready_out = id_ready_in | ~m_v (combinational).
//   Main-reg update identical with s_v fixed 0; flush/reset rules unchanged.
// TESTING
// - Reset: rst=1 for 2 cycles -> id_valid_out=0, inst_out=32'h13, inst_addr_out=0, if_ready_out=1.
// - Stream: id_ready_in=1; push 0x00500093@0x0, 0x00A00113@0x4, 0x002081B3@0x8 back-to-back
//   -> each appears on outputs exactly 1 cycle later, in order, id_valid_out=1 for 3 cycles.
// - Stall: hold id_ready_in=0 while pushing A@0x0, B@0x4, C@0x8 -> A held on outputs, B in skid,
//   if_ready_out=0, C not accepted; release -> A, B, C (C after re-offer) with no loss.
// - Flush during stall: main=A, skid=B, flush_in=1 with C offered -> next cycle id_valid_out=0,
//   inst_out=32'h13, if_ready_out=1; following D@0x20 accepted and output 1 cycle later.
// - Simultaneous rst+flush+valid: rst wins, reset values next cycle.
// - Without CORE_IF_ID_SKID_EN: id_ready_in=0 with m_v=1 -> if_ready_out=0 same cycle;
//   streaming and flush tests give identical output sequences.

Source files
------------

// File: rtl/core_if_id.sv
// IF->ID pipeline register with valid/ready on both sides and an optional
// skid entry (CORE_IF_ID_SKID_EN) so that if_ready_out comes from a flop.
// Ports: clk, rst (sync, active-high); fetch side if_valid_in, if_ready_out,
// inst_in, inst_addr_in; flush_in; decode side id_ready_in, id_valid_out,
// inst_out, inst_addr_out.
// Without CORE_IF_ID_SKID_EN, if_ready_out = id_ready_in | ~main valid.
module core_if_id #(
  parameter int                INST_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_in,
  output logic              if_ready_out,
  input  logic [INST_W-1:0] inst_in,
  input  logic [ADDR_W-1:0] inst_addr_in,
  input  logic              flush_in,
  input  logic              id_ready_in,
  output logic              id_valid_out,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_addr_out
);

  logic              m_v_q, m_v_d;
  logic [INST_W-1:0] m_inst_q, m_inst_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              advance;
  logic              accept;

`ifdef CORE_IF_ID_SKID_EN
  logic              s_v_q, s_v_d;
  logic [INST_W-1:0] s_inst_q, s_inst_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;

  assign if_ready_out = ~s_v_q;
`else
  assign if_ready_out = id_ready_in | ~m_v_q;
`endif

  assign advance = id_ready_in | ~m_v_q;
  assign accept  = if_valid_in & if_ready_out;

  assign id_valid_out  = m_v_q;
  assign inst_out      = m_inst_q;
  assign inst_addr_out = m_addr_q;

  always_comb begin
    m_v_d    = m_v_q;
    m_inst_d = m_inst_q;
    m_addr_d = m_addr_q;
`ifdef CORE_IF_ID_SKID_EN
    s_v_d    = s_v_q;
    s_inst_d = s_inst_q;
    s_addr_d = s_addr_q;
`endif
    if (flush_in) begin
      // Bubble out; address is left as-is.
      m_v_d    = 1'b0;
      m_inst_d = NOP_INST;
`ifdef CORE_IF_ID_SKID_EN
      s_v_d    = 1'b0;
`endif
    end else if (advance) begin
`ifdef CORE_IF_ID_SKID_EN
      if (s_v_q) begin
        // Skid drains first to keep program order.
        m_v_d    = 1'b1;
        m_inst_d = s_inst_q;
        m_addr_d = s_addr_q;
        s_v_d    = accept;
        if (accept) begin
          s_inst_d = inst_in;
          s_addr_d = inst_addr_in;
        end
      end else if (accept) begin
        m_v_d    = 1'b1;
        m_inst_d = inst_in;
        m_addr_d = inst_addr_in;
      end else begin
        m_v_d    = 1'b0;
        m_inst_d = NOP_INST;
      end
`else
      if (accept) begin
        m_v_d    = 1'b1;
        m_inst_d = inst_in;
        m_addr_d = inst_addr_in;
      end else begin
        m_v_d    = 1'b0;
        m_inst_d = NOP_INST;
      end
`endif
    end
`ifdef CORE_IF_ID_SKID_EN
    else if (accept) begin
      // Main stalled: park the beat; ready drops next cycle.
      s_v_d    = 1'b1;
      s_inst_d = inst_in;
      s_addr_d = inst_addr_in;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_q    <= 1'b0;
      m_inst_q <= NOP_INST;
      m_addr_q <= '0;
`ifdef CORE_IF_ID_SKID_EN
      s_v_q    <= 1'b0;
      s_inst_q <= NOP_INST;
      s_addr_q <= '0;
`endif
    end else begin
      m_v_q    <= m_v_d;
      m_inst_q <= m_inst_d;
      m_addr_q <= m_addr_d;
`ifdef CORE_IF_ID_SKID_EN
      s_v_q    <= s_v_d;
      s_inst_q <= s_inst_d;
      s_addr_q <= s_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_core_if_id.sv
// Bench for core_if_id: directed tables and sequences plus random traffic
// checked against a queue model of the held beats.
module tb_core_if_id;

`ifdef CORE_IF_ID_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, if_valid_in, flush_in, id_ready_in;
  logic        if_ready_out, id_valid_out;
  logic [31:0] inst_in, inst_addr_in, inst_out, inst_addr_out;

  always #5 clk = ~clk;

  core_if_id dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid_in  (if_valid_in),
    .if_ready_out (if_ready_out),
    .inst_in      (inst_in),
    .inst_addr_in (inst_addr_in),
    .flush_in     (flush_in),
    .id_ready_in  (id_ready_in),
    .id_valid_out (id_valid_out),
    .inst_out     (inst_out),
    .inst_addr_out(inst_addr_out)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } beat_t;

  beat_t       mq[$];
  logic [31:0] m_last;
  logic [31:0] consumed[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, check ready, advance model, check outputs.
  task automatic cycle(input bit r, input bit f, input bit v,
                       input logic [31:0] i, input logic [31:0] a,
                       input bit idr, output bit acc);
    bit rdy;
    rst = r; flush_in = f; if_valid_in = v;
    inst_in = i; inst_addr_in = a; id_ready_in = idr;
    #1;
    rdy = SKID ? (mq.size() < 2) : (mq.size() == 0 || idr);
    chk("if_ready_out", {31'd0, if_ready_out}, {31'd0, rdy});
    acc = v && rdy;
    if (idr && id_valid_out) consumed.push_back(inst_out);
    if (r) begin
      mq.delete();
      m_last = '0;
    end else if (f) begin
      mq.delete();
    end else begin
      if (idr && mq.size() > 0) void'(mq.pop_front());
      if (acc) mq.push_back('{i, a});
    end
    if (mq.size() > 0) m_last = mq[0].addr;
    @(posedge clk);
    #1;
    chk("id_valid_out", {31'd0, id_valid_out},
        {31'd0, mq.size() > 0});
    chk("inst_out", inst_out, mq.size() > 0 ? mq[0].inst : NOP);
    chk("inst_addr_out", inst_addr_out, m_last);
  endtask

  typedef struct {
    bit          r, f, v;
    logic [31:0] i, a;
    bit          idr;
    bit          ev;
    logic [31:0] ei, ea;
  } vec_t;

  vec_t        tbl[5];
  beat_t       sb[3];
  logic [31:0] seen_exp[3];
  bit          acc;
  int          idx;
  int          guard;

  initial begin
    tbl[0] = '{1, 0, 0, 32'h0, 32'h0, 1, 0, NOP, 32'h0};
    tbl[1] = '{0, 0, 1, 32'h00500093, 32'h0, 1, 1, 32'h00500093, 32'h0};
    tbl[2] = '{0, 0, 1, 32'h00A00113, 32'h4, 1, 1, 32'h00A00113, 32'h4};
    tbl[3] = '{0, 0, 1, 32'h002081B3, 32'h8, 1, 1, 32'h002081B3, 32'h8};
    tbl[4] = '{0, 0, 0, 32'h0, 32'h0, 1, 0, NOP, 32'h8};

    // First reset cycle: state unknown beforehand, so only drive.
    rst = 1; flush_in = 0; if_valid_in = 0;
    inst_in = 0; inst_addr_in = 0; id_ready_in = 0;
    m_last = '0;
    @(posedge clk);
    #1;

    // Reset tail and a back-to-back stream.
    for (int k = 0; k < 5; k++) begin
      cycle(tbl[k].r, tbl[k].f, tbl[k].v, tbl[k].i, tbl[k].a,
            tbl[k].idr, acc);
      chk($sformatf("tbl%0d_valid", k), {31'd0, id_valid_out},
          {31'd0, tbl[k].ev});
      chk($sformatf("tbl%0d_inst", k), inst_out, tbl[k].ei);
      chk($sformatf("tbl%0d_addr", k), inst_addr_out, tbl[k].ea);
    end

    // Stall with three offers, then release.
    sb[0] = '{32'hA0000001, 32'h0};
    sb[1] = '{32'hB0000002, 32'h4};
    sb[2] = '{32'hC0000003, 32'h8};
    consumed.delete();
    idx = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 1, sb[idx].inst, sb[idx].addr, 0, acc);
      if (acc) idx++;
    end
    chk("stall_ready", {31'd0, if_ready_out}, 32'd0);
    chk("stall_head", inst_out, sb[0].inst);
    guard = 0;
    while (consumed.size() < 3 && guard < 12) begin
      if (idx < 3) cycle(0, 0, 1, sb[idx].inst, sb[idx].addr, 1, acc);
      else cycle(0, 0, 0, 32'h0, 32'h0, 1, acc);
      if (acc) idx++;
      guard++;
    end
    chk("stall_drain_count", consumed.size(), 32'd3);
    seen_exp[0] = 32'hA0000001;
    seen_exp[1] = 32'hB0000002;
    seen_exp[2] = 32'hC0000003;
    for (int k = 0; k < 3; k++)
      chk($sformatf("stall_order%0d", k),
          k < consumed.size() ? consumed[k] : 32'hx, seen_exp[k]);

    // Flush while stalled with a beat on offer.
    cycle(0, 0, 1, sb[0].inst, sb[0].addr, 0, acc);
    cycle(0, 0, 1, sb[1].inst, sb[1].addr, 0, acc);
    cycle(0, 1, 1, sb[2].inst, sb[2].addr, 0, acc);
    chk("flush_valid", {31'd0, id_valid_out}, 32'd0);
    chk("flush_inst", inst_out, NOP);
    chk("flush_ready", {31'd0, if_ready_out}, 32'd1);
    cycle(0, 0, 1, 32'hD0000004, 32'h20, 0, acc);
    chk("flush_d_valid", {31'd0, id_valid_out}, 32'd1);
    chk("flush_d_inst", inst_out, 32'hD0000004);
    chk("flush_d_addr", inst_addr_out, 32'h20);

    // Reset beats flush and a valid offer.
    cycle(0, 0, 1, 32'hE0000005, 32'h24, 0, acc);
    cycle(1, 1, 1, 32'hF0000006, 32'h28, 1, acc);
    chk("rstwin_valid", {31'd0, id_valid_out}, 32'd0);
    chk("rstwin_inst", inst_out, NOP);
    chk("rstwin_addr", inst_addr_out, 32'h0);
    cycle(0, 0, 0, 32'h0, 32'h0, 0, acc);
    chk("rstwin_ready", {31'd0, if_ready_out}, 32'd1);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 49) == 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 3) != 0,
            $urandom, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 2) != 0, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
